// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller. One transaction is START, 7-bit
// address + R/W, 0..15 data bytes (written from a byte stream or read into one),
// then STOP. SCL is derived from clk with CLK_DIV clk cycles per quarter period.
// Optional build macro I2C_CLK_STRETCH_EN: when defined, the high phase of SCL
// waits for the bus to actually read high (slave clock stretching).
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       nack,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [1:0]         q, q_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [7:0]         shift, shift_n;
  logic [LEN_W-1:0]   rem, rem_n;
  logic [LEN_W-1:0]   len_r, len_n;
  logic               rw_r, rw_n;
  logic               samp, samp_n;
  logic               have, have_n;
  logic               scl_low, scl_low_n;
  logic               sda_low, sda_low_n;
  logic               cmd_ready_n, wr_ready_n, rd_valid_n, busy_n, done_n, nack_n;
  logic [7:0]         rd_data_n;

  logic tick_c, wstall_c, stretch_c, adv_c;
  logic enter_q1_c, enter_q2_c, enter_q3_c, slot_end_c;

  // Open-drain pads: only ever pull low or release
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Quarter timing: divider wrap, write-byte stall and optional stretch hold
  assign tick_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign wstall_c = (state == S_WDATA) && (q == 2'd0) && (bit_cnt == '0) && !have;
`ifdef I2C_CLK_STRETCH_EN
  assign stretch_c = (q == 2'd2) && (scl == 1'b0);
`else
  assign stretch_c = 1'b0;
`endif
  assign adv_c      = tick_c && !stretch_c && !wstall_c && (state != S_IDLE);
  assign enter_q1_c = adv_c && (q == 2'd0);
  assign enter_q2_c = adv_c && (q == 2'd1);
  assign enter_q3_c = adv_c && (q == 2'd2);
  assign slot_end_c = adv_c && (q == 2'd3);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      q         <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rem       <= '0;
      len_r     <= '0;
      rw_r      <= 1'b0;
      samp      <= 1'b0;
      have      <= 1'b0;
      scl_low   <= 1'b0;
      sda_low   <= 1'b0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      q         <= q_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      rem       <= rem_n;
      len_r     <= len_n;
      rw_r      <= rw_n;
      samp      <= samp_n;
      have      <= have_n;
      scl_low   <= scl_low_n;
      sda_low   <= sda_low_n;
      cmd_ready <= cmd_ready_n;
      wr_ready  <= wr_ready_n;
      rd_data   <= rd_data_n;
      rd_valid  <= rd_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      nack      <= nack_n;
    end
  end

  // Next-state, bus drive and handshake logic
  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    q_n         = q;
    bit_n       = bit_cnt;
    shift_n     = shift;
    rem_n       = rem;
    len_n       = len_r;
    rw_n        = rw_r;
    samp_n      = samp;
    have_n      = have;
    scl_low_n   = scl_low;
    sda_low_n   = sda_low;
    cmd_ready_n = cmd_ready;
    wr_ready_n  = 1'b0;
    rd_data_n   = rd_data;
    rd_valid_n  = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    nack_n      = nack;

    if (state == S_IDLE || wstall_c) begin
      div_n = '0;
    end else if (tick_c) begin
      div_n = stretch_c ? div_cnt : '0;
    end else begin
      div_n = div_cnt + DIV_W'(1);
    end
    if (adv_c) begin
      q_n = q + 2'd1;
    end

    unique case (state)
      S_IDLE: begin
        scl_low_n = 1'b0;
        sda_low_n = 1'b0;
        q_n       = '0;
        bit_n     = '0;
        have_n    = 1'b0;
        if (cmd_valid && cmd_ready) begin
          shift_n     = {cmd_addr, cmd_rw};
          rw_n        = cmd_rw;
          len_n       = cmd_len;
          nack_n      = 1'b0;
          busy_n      = 1'b1;
          cmd_ready_n = 1'b0;
          state_n     = S_START;
        end
      end

      S_START: begin
        if (enter_q2_c) sda_low_n = 1'b1;
        if (slot_end_c) begin
          scl_low_n = 1'b1;
          bit_n     = '0;
          state_n   = S_ADDR;
        end
      end

      S_ADDR, S_WDATA: begin
        if (wstall_c && wr_valid) begin
          shift_n    = wr_data;
          have_n     = 1'b1;
          wr_ready_n = 1'b1;
        end
        if (enter_q1_c) sda_low_n = ~shift[7];
        if (enter_q2_c) scl_low_n = 1'b0;
        if (slot_end_c) begin
          scl_low_n = 1'b1;
          shift_n   = {shift[6:0], 1'b0};
          if (bit_cnt == BIT_W'(7)) begin
            bit_n   = '0;
            have_n  = 1'b0;
            state_n = (state == S_ADDR) ? S_ADDR_ACK : S_WACK;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end

      S_ADDR_ACK, S_WACK: begin
        if (enter_q1_c) sda_low_n = 1'b0;
        if (enter_q2_c) scl_low_n = 1'b0;
        if (enter_q3_c) samp_n = sda;
        if (slot_end_c) begin
          scl_low_n = 1'b1;
          bit_n     = '0;
          if (samp) begin
            nack_n  = 1'b1;
            state_n = S_STOP;
          end else if (state == S_ADDR_ACK) begin
            rem_n = len_r;
            if (len_r == '0)  state_n = S_STOP;
            else if (rw_r)    state_n = S_RDATA;
            else              state_n = S_WDATA;
          end else begin
            rem_n   = rem - LEN_W'(1);
            state_n = (rem > LEN_W'(1)) ? S_WDATA : S_STOP;
          end
        end
      end

      S_RDATA: begin
        if (enter_q1_c) sda_low_n = 1'b0;
        if (enter_q2_c) scl_low_n = 1'b0;
        if (enter_q3_c) shift_n = {shift[6:0], sda};
        if (slot_end_c) begin
          scl_low_n = 1'b1;
          if (bit_cnt == BIT_W'(7)) begin
            rd_data_n  = shift;
            rd_valid_n = 1'b1;
            bit_n      = '0;
            state_n    = S_RACK;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end

      S_RACK: begin
        if (enter_q1_c) sda_low_n = (rem > LEN_W'(1));
        if (enter_q2_c) scl_low_n = 1'b0;
        if (slot_end_c) begin
          scl_low_n = 1'b1;
          rem_n     = rem - LEN_W'(1);
          state_n   = (rem > LEN_W'(1)) ? S_RDATA : S_STOP;
        end
      end

      S_STOP: begin
        if (enter_q1_c) sda_low_n = 1'b1;
        if (enter_q2_c) scl_low_n = 1'b0;
        if (enter_q3_c) sda_low_n = 1'b0;
        if (slot_end_c) begin
          done_n      = 1'b1;
          busy_n      = 1'b0;
          cmd_ready_n = 1'b1;
          q_n         = '0;
          state_n     = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
